// File: rtl/filter_sample_feeder_if.sv
// rtl/filter_sample_feeder_if.sv - sample/filter handshake bundle for filter_sample_feeder
interface filter_sample_feeder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             filt_ready;
    logic [WIDTH-1:0] x;
    logic             start;

    modport master (
        output in_data, in_valid, filt_ready,
        input  in_ready, x, start
    );

    modport slave (
        input  in_data, in_valid, filt_ready,
        output in_ready, x, start
    );
endinterface

// File: rtl/filter_sample_feeder.sv
// rtl/filter_sample_feeder.sv - FIFO-buffered sample issuer for the symmetric FIR filter
module filter_sample_feeder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    filter_sample_feeder_if.slave bus,
    output logic [AW:0]          count,
    output logic [15:0]          launched,
    output logic                 overflow,
    output logic                 ack_err
);

    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]    FULL    = (AW + 1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WD_W-1:0]  watchdog;
    logic             full;
    logic             push;
    logic             pop;

    assign full        = (count == FULL);
    assign bus.in_ready = ~full;
    assign push        = bus.in_valid & ~full;
    // Pop is tied to the launch decision; a full FIFO still refuses the push in that cycle.
    assign pop         = (state == IDLE) && (count != '0) && bus.filt_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // x is only written on a launch, so it stays put for the whole start window and beyond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus.x     <= '0;
            bus.start <= 1'b0;
            launched  <= '0;
            watchdog  <= '0;
            ack_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.x     <= mem[rd_ptr];
                        bus.start <= 1'b1;
                        launched  <= launched + 16'd1;
                        state     <= LAUNCH;
                    end else begin
                        bus.start <= 1'b0;
                    end
                end
                LAUNCH: begin
                    bus.start <= 1'b1;
                    watchdog  <= '0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.filt_ready) begin
                        bus.start <= 1'b0;
                        state     <= WAIT_DONE;
                    end else if (watchdog == WD_LAST) begin
                        bus.start <= 1'b0;
                        ack_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (bus.filt_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_sample_feeder.sv
// tb/tb_filter_sample_feeder.sv - self-checking bench for filter_sample_feeder
module tb_filter_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  count;
    logic [15:0] launched;
    logic        overflow;
    logic        ack_err;

    always #5 clk = ~clk;

    filter_sample_feeder_if #(.WIDTH(32)) bus();

    filter_sample_feeder #(.WIDTH(32), .DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .count    (count),
        .launched (launched),
        .overflow (overflow),
        .ack_err  (ack_err)
    );

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        fr;
        logic        exp_start;
        logic [31:0] exp_x;
        logic [4:0]  exp_count;
        logic [15:0] exp_launched;
    } vec_t;

    vec_t        vecs [16];
    int          checks = 0;
    int          errors = 0;
    int          busy = 0;
    bit          auto_filt = 1'b0;
    logic        prev_start = 1'b0;
    logic [31:0] prev_x = '0;
    logic [31:0] exp_q [$];
    logic [31:0] model_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        prev_start = bus.start;
        prev_x     = bus.x;
        @(posedge clk);
        #1;
    endtask

    // Abstract filter: accepts a start while idle, stays busy a random while, then returns ready.
    task automatic filt_step();
        if (auto_filt) begin
            if (busy == 0 && bus.start && bus.filt_ready) begin
                busy = int'($urandom_range(2, 8));
                bus.filt_ready = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) bus.filt_ready = 1'b1;
            end
        end
    endtask

    initial begin
        int n;
        int nlaunch;
        int pre;
        bit acc;
        bit exp_ovf;
        logic [31:0] d;
        logic [31:0] h;

        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.filt_ready = 1'b1;

        vecs[0]  = '{1'b1, 32'h3F800000, 1'b1, 1'b0, 32'h0,        5'd1, 16'd0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3F800000, 5'd0, 16'd1};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3F800000, 5'd0, 16'd1};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h3F800000, 5'd0, 16'd1};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h3F800000, 5'd0, 16'd1};
        vecs[5]  = '{1'b1, 32'h11110001, 1'b0, 1'b0, 32'h3F800000, 5'd1, 16'd1};
        vecs[6]  = '{1'b1, 32'h22220002, 1'b0, 1'b0, 32'h3F800000, 5'd2, 16'd1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h3F800000, 5'd2, 16'd1};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11110001, 5'd1, 16'd2};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11110001, 5'd1, 16'd2};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h11110001, 5'd1, 16'd2};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h11110001, 5'd1, 16'd2};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22220002, 5'd0, 16'd3};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22220002, 5'd0, 16'd3};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h22220002, 5'd0, 16'd3};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h22220002, 5'd0, 16'd3};

        // Reset state
        tick(); tick();
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_x", bus.x, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_launched", 32'(launched), 32'd0);
        check("rst_flags", {30'd0, overflow, ack_err}, 32'd0);
        rst = 1'b1;

        // Single sample and back-to-back launches, one row per cycle
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = vecs[i].in_valid;
            bus.in_data = vecs[i].in_data;
            bus.filt_ready = vecs[i].fr;
            tick();
            check($sformatf("vec%0d_start", i), 32'(bus.start), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_x", i), bus.x, vecs[i].exp_x);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_launched", i), 32'(launched), 32'(vecs[i].exp_launched));
        end
        bus.in_valid = 1'b0;

        // Fill to DEPTH while the filter is busy
        bus.filt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'd100 + 32'(i);
            tick();
        end
        check("full_count", 32'(count), 32'd16);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_no_start", 32'(bus.start), 32'd0);
        check("full_ovf_clear", 32'(overflow), 32'd0);
        bus.in_data = 32'h00000BAD;
        tick();
        check("drop17_count", 32'(count), 32'd16);
        check("drop17_ovf", 32'(overflow), 32'd1);

        // Launch pop while full and in_valid: push refused this cycle, accepted the next
        bus.in_data = 32'h00000999;
        bus.filt_ready = 1'b1;
        tick();
        check("simul_count", 32'(count), 32'd15);
        check("simul_start", 32'(bus.start), 32'd1);
        check("simul_x", bus.x, 32'd100);
        tick();
        check("simul_next_count", 32'(count), 32'd16);
        bus.in_valid = 1'b0;

        // Drain with the abstract filter; order must follow push order
        exp_q.delete();
        for (int i = 1; i < 16; i++) exp_q.push_back(32'd100 + 32'(i));
        exp_q.push_back(32'h00000999);
        auto_filt = 1'b1;
        busy = 0;
        filt_step();
        n = 0;
        while (exp_q.size() != 0 && n < 800) begin
            tick();
            n++;
            if (bus.start && !prev_start) begin
                h = exp_q.pop_front();
                check("drain_x", bus.x, h);
            end
            filt_step();
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            filt_step();
        end
        check("drain_launched", 32'(launched), 32'd20);
        check("drain_count", 32'(count), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        auto_filt = 1'b0;

        // Watchdog: filter never drops ready after a launch
        bus.filt_ready = 1'b1;
        check("wd_ack_err_clear", 32'(ack_err), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0000DEAD;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("wd_launch_start", 32'(bus.start), 32'd1);
        check("wd_launch_x", bus.x, 32'h0000DEAD);
        n = 0;
        while (bus.start && n < 30) begin
            tick();
            n++;
        end
        check("wd_start_cycles", 32'(n), 32'd9);
        check("wd_ack_err", 32'(ack_err), 32'd1);
        check("wd_launched", 32'(launched), 32'd21);
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0000BEEF;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("wd_relaunch_start", 32'(bus.start), 32'd1);
        check("wd_relaunch_x", bus.x, 32'h0000BEEF);
        check("wd_relaunch_launched", 32'(launched), 32'd22);
        bus.filt_ready = 1'b0;
        tick(); tick();
        check("wd_relaunch_drop", 32'(bus.start), 32'd0);

        // Asynchronous reset mid WAIT_ACK
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5;
        tick();
        bus.in_data = 32'd6;
        tick();
        bus.in_valid = 1'b0;
        bus.filt_ready = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_start", 32'(bus.start), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_start", 32'(bus.start), 32'd0);
        check("arst_x", bus.x, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_launched", 32'(launched), 32'd0);
        check("arst_flags", {30'd0, overflow, ack_err}, 32'd0);
        tick();
        rst = 1'b1;

        // Randomized traffic against a queue-based model
        model_q.delete();
        exp_ovf = 1'b0;
        nlaunch = 0;
        busy = 0;
        auto_filt = 1'b1;
        bus.filt_ready = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid = (cyc < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            d = $urandom;
            bus.in_data = d;
            check("rnd_in_ready", 32'(bus.in_ready), 32'(model_q.size() != 16));
            acc = bus.in_valid && (model_q.size() != 16);
            if (bus.in_valid && model_q.size() == 16) exp_ovf = 1'b1;
            pre = model_q.size();
            tick();
            if (acc) model_q.push_back(d);
            if (bus.start && !prev_start) begin
                nlaunch++;
                check("rnd_launch_nonempty", 32'(pre != 0), 32'd1);
                if (model_q.size() != 0) begin
                    h = model_q.pop_front();
                    check("rnd_x", bus.x, h);
                end
            end
            if (bus.start && prev_start) check("rnd_x_stable", bus.x, prev_x);
            check("rnd_count", 32'(count), 32'(model_q.size()));
            check("rnd_launched", 32'(launched), 32'(16'(nlaunch)));
            check("rnd_overflow", 32'(overflow), 32'(exp_ovf));
            check("rnd_ack_err", 32'(ack_err), 32'd0);
            filt_step();
        end
        bus.in_valid = 1'b0;
        check("rnd_launch_activity", 32'(nlaunch > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
